// File: rtl/snd_bus_ctrl.sv
// Sound-side bus controller.
// Arbitrates the single port of the 64 KB sound RAM between the Z80, the main
// CPU sound window and the ROM download loader. It requests the bus from the
// Z80 with BUSRQ_n/BUSAK_n and holds the Z80/YM2151 in reset while the RAM is
// borrowed, releasing them a fixed number of cycles after the handover ends.

module snd_bus_ctrl #(
    parameter int AW          = 16,
    parameter int RST_CYCLES  = 64,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic          CLK_32M,
    input  logic          RESET_n,

    // Main CPU side
    input  logic          BRQ,
    input  logic          SDBEN,
    input  logic          MRD,
    input  logic          MWR,
    input  logic [AW-1:0] A,
    input  logic [7:0]    DIN,

    // ROM download loader
    input  logic          ld_req,
    input  logic          ld_wr,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,

    // Z80 side
    input  logic [AW-1:0] z80_addr,
    input  logic [7:0]    z80_dout,
    input  logic          z80_mreq_n,
    input  logic          z80_wr_n,
    input  logic          z80_busak_n,
    output logic          z80_busrq_n,
    output logic          snd_rst,

    // Shared RAM port
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_data,
    output logic          ram_we,
    output logic          cpu_dout_valid,
    output logic [1:0]    owner
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_RST  = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd1;
    localparam logic [2:0] ST_REQ  = 3'd2;
    localparam logic [2:0] ST_CPU  = 3'd3;
    localparam logic [2:0] ST_LOAD = 3'd4;
    localparam logic [2:0] ST_REL  = 3'd5;

    localparam logic [1:0] OWN_Z80  = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_LOAD = 2'd2;
    localparam logic [1:0] OWN_HAND = 2'd3;

    // One shared down-counter serves both the reset pulse and the
    // acknowledge timeout, so it is sized for the longer of the two.
    localparam int CNT_MAX = (RST_CYCLES > ACK_TIMEOUT) ? RST_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [AW-1:0]    ram_addr_q, ram_addr_d;
    logic [7:0]       ram_data_q, ram_data_d;
    logic             ram_we_q, ram_we_d;

    // Read strobe pipeline: stage 1 aligns with the registered address,
    // stage 2 aligns with the RAM's registered q.
    logic             rd_pend_q, rd_pend_d;
    logic             rd_valid_q;

    logic             any_req;
    logic             cnt_zero;
    logic             ack_seen;

    assign any_req  = BRQ | ld_req;
    assign cnt_zero = (cnt_q == '0);
    assign ack_seen = ~z80_busak_n;

    // Next-state and counter control for the ownership sequence.
    // NOTE: every signal assigned in a combinational block gets a default at
    // the top; otherwise a path that skips the assignment infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_RST: begin
                if (cnt_zero) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_RUN: begin
                if (any_req) begin
                    state_d = ST_REQ;
                    cnt_d   = ACK_LOAD;
                end
            end

            ST_REQ: begin
                if (!any_req) begin
                    // Requester gave up before the grant; the Z80 is still
                    // restarted because it may have been stopped mid-access.
                    state_d = ST_REL;
                    cnt_d   = RST_LOAD;
                end else if (ack_seen || cnt_zero) begin
                    // Loader wins if both are pending at the grant.
                    state_d = ld_req ? ST_LOAD : ST_CPU;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_CPU: begin
                if (ld_req) begin
                    state_d = ST_LOAD;
                end else if (!BRQ) begin
                    state_d = ST_REL;
                    cnt_d   = RST_LOAD;
                end
            end

            ST_LOAD: begin
                if (!ld_req) begin
                    if (BRQ) begin
                        state_d = ST_CPU;
                    end else begin
                        state_d = ST_REL;
                        cnt_d   = RST_LOAD;
                    end
                end
            end

            ST_REL: begin
                if (any_req) begin
                    // Abandon the restart and take the bus again.
                    state_d = ST_REQ;
                    cnt_d   = ACK_LOAD;
                end else if (cnt_zero) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = ST_RST;
                cnt_d   = RST_LOAD;
            end
        endcase
    end

    // RAM port mux: only the current owner's strobe reaches the write enable.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_we_d   = 1'b0;

        case (state_q)
            ST_RST: begin
                ram_addr_d = '0;
                ram_data_d = '0;
            end

            ST_RUN: begin
                ram_addr_d = z80_addr;
                ram_data_d = z80_dout;
                ram_we_d   = ~z80_mreq_n & ~z80_wr_n;
            end

            ST_CPU: begin
                ram_addr_d = A;
                ram_data_d = DIN;
                ram_we_d   = MWR & SDBEN;
            end

            ST_LOAD: begin
                ram_addr_d = ld_addr;
                ram_data_d = ld_data;
                ram_we_d   = ld_wr;
            end

            default: begin
                // REQ / REL: nobody owns the port, hold address and data.
                ram_we_d = 1'b0;
            end
        endcase
    end

    // A CPU read only counts while the CPU actually owns the port.
    always_comb begin
        rd_pend_d = MRD & SDBEN & (state_q == ST_CPU);
    end

    // Registered state, counter and RAM port with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK_32M) begin
        if (!RESET_n) begin
            state_q    <= ST_RST;
            cnt_q      <= RST_LOAD;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
            rd_pend_q  <= rd_pend_d;
            rd_valid_q <= rd_pend_q;
        end
    end

    // Handshake and ownership decode; these follow the state register so
    // they change on the same edge as the state.
    always_comb begin
        owner       = OWN_HAND;
        z80_busrq_n = 1'b1;
        snd_rst     = 1'b1;

        case (state_q)
            ST_RST: begin
                owner       = OWN_HAND;
                z80_busrq_n = 1'b1;
                snd_rst     = 1'b1;
            end

            ST_RUN: begin
                owner       = OWN_Z80;
                z80_busrq_n = 1'b1;
                snd_rst     = 1'b0;
            end

            ST_REQ: begin
                // Z80 keeps running until it acknowledges or is forced off.
                owner       = OWN_HAND;
                z80_busrq_n = 1'b0;
                snd_rst     = 1'b0;
            end

            ST_CPU: begin
                owner       = OWN_CPU;
                z80_busrq_n = 1'b0;
                snd_rst     = 1'b1;
            end

            ST_LOAD: begin
                owner       = OWN_LOAD;
                z80_busrq_n = 1'b0;
                snd_rst     = 1'b1;
            end

            ST_REL: begin
                owner       = OWN_HAND;
                z80_busrq_n = 1'b1;
                snd_rst     = 1'b1;
            end

            default: begin
                owner       = OWN_HAND;
                z80_busrq_n = 1'b1;
                snd_rst     = 1'b1;
            end
        endcase
    end

    assign ram_addr       = ram_addr_q;
    assign ram_data       = ram_data_q;
    assign ram_we         = ram_we_q;
    assign cpu_dout_valid = rd_valid_q;

endmodule

// File: doc/snd_bus_ctrl.md
# snd_bus_ctrl

Bus controller for the sound subsystem's 64 KB shared RAM and its Z80/YM2151 pair. It arbitrates the single RAM port between three requesters: the Z80, the main CPU sound window, and the ROM download loader. It uses a request/acknowledge handshake with the Z80 (BUSRQ_n/BUSAK_n). It also generates the sound-side reset sequence that restarts the Z80 and YM2151 after the RAM has been rewritten.

## Interface
Parameters:
- AW, 16, RAM address width
- RST_CYCLES, 64, length of the sound reset pulse after a bus handover, in CLK_32M cycles
- ACK_TIMEOUT, 1023, maximum cycles to wait for BUSAK_n before forcing the grant

Ports:
- CLK_32M  in  1  system clock; all logic on the rising edge
- RESET_n  in  1  synchronous, active-low reset
- BRQ  in  1  main CPU bus request, level
- SDBEN  in  1  main CPU sound-window select
- MRD, MWR  in  1  main CPU read / write strobes
- A  in  AW  main CPU address
- DIN  in  8  main CPU write data
- ld_req  in  1  loader request, level
- ld_wr  in  1  loader write strobe
- ld_addr  in  AW  loader address
- ld_data  in  8  loader write data
- z80_addr  in  AW  Z80 address
- z80_dout  in  8  Z80 write data
- z80_mreq_n, z80_wr_n  in  1  Z80 bus strobes
- z80_busak_n  in  1  Z80 bus acknowledge
- z80_busrq_n  out  1  Z80 bus request
- snd_rst  out  1  active-high reset to the Z80 and YM2151
- ram_addr  out  AW  RAM address, registered
- ram_data  out  8  RAM write data, registered
- ram_we  out  1  RAM write enable, registered
- cpu_dout_valid  out  1  main CPU read data on the RAM q port is valid
- owner  out  2  current owner: 0 = Z80, 1 = CPU, 2 = loader, 3 = handover

## Operation
States: RST, RUN, REQ, CPU, LOAD, REL.

RST
- Entered while RESET_n = 0, and on leaving RESET_n low.
- Outputs held: z80_busrq_n = 1, snd_rst = 1, ram_we = 0, cpu_dout_valid = 0, owner = 3, ram_addr = 0, ram_data = 0.
- Counter loads RST_CYCLES-1 and counts down. On reaching 0 the block goes to RUN.

RUN
- owner = 0 and snd_rst = 0.
- The RAM follows the Z80: ram_addr = z80_addr, ram_data = z80_dout, ram_we = ~z80_mreq_n & ~z80_wr_n.
- If ld_req or BRQ is high, the block goes to REQ and asserts z80_busrq_n = 0.

REQ
- The block waits for z80_busak_n = 0 or for ACK_TIMEOUT cycles to elapse, whichever comes first.
- ram_we = 0 while in REQ.
- On exit it goes to LOAD if ld_req = 1, otherwise to CPU. The loader has priority because ld_req is sampled at the exit cycle.
- If both requests drop before the acknowledge, the block goes to REL. The Z80 is reset regardless.

CPU
- owner = 1, z80_busrq_n = 0, snd_rst = 1.
- ram_addr = A, ram_data = DIN, ram_we = MWR & SDBEN.
- If ld_req rises, the block goes directly to LOAD.
- When BRQ = 0 and ld_req = 0, the block goes to REL.

LOAD
- owner = 2, z80_busrq_n = 0, snd_rst = 1.
- ram_addr = ld_addr, ram_data = ld_data, ram_we = ld_wr.
- When ld_req = 0: go to CPU if BRQ = 1, otherwise to REL.

REL
- owner = 3, z80_busrq_n = 1, snd_rst = 1.
- The counter runs RST_CYCLES cycles, then the block goes to RUN.
- If a new BRQ or ld_req arrives during REL, the block returns to REQ and the counter is abandoned.

Common rules
- cpu_dout_valid = registered (MRD & SDBEN & state == CPU).
- CPU reads outside the CPU state never produce a valid pulse.
- Only the owner's write reaches ram_we. Strobes from non-owners are dropped; there is no buffering.

## Timing
- RAM outputs are registered, one cycle after the source strobe. A write strobe at edge N gives ram_we at N+1.
- RAM read latency is 1 cycle after the address. cpu_dout_valid is high in the cycle in which the RAM q for the address registered with the strobe is valid.
- z80_busrq_n changes at the edge on which the state changes.
- REQ→CPU/LOAD transition: 1 cycle after BUSAK_n is sampled low. In the timeout case, exactly ACK_TIMEOUT cycles after REQ entry.
- snd_rst rises on the REQ→CPU/LOAD edge. It falls RST_CYCLES cycles after REL entry.
- Reset mid-operation: on any edge with RESET_n = 0, the state is RST, ram_we = 0 and cpu_dout_valid = 0 at the next output.

## Test plan
- Reset, then Z80 writes 0x5A to 0x1234 → ram_addr = 0x1234, ram_data = 0x5A, ram_we = 1 one cycle later; owner = 0 once RST_CYCLES has elapsed.
- BRQ high, BUSAK_n low after 5 cycles → owner = 1 on the 6th cycle. A CPU MWR to 0x0100 with DIN = 0xC3 writes the RAM. A Z80 write in the same cycle is dropped.
- ld_req raised while in CPU → owner = 2 on the next edge. 256 loader writes all land. After ld_req drops with BRQ = 0, snd_rst stays high for exactly 64 cycles, then owner = 0.
- BUSAK_n never asserts → grant forced after 1023 cycles; z80_busrq_n stays 0 throughout.
- CPU MRD & SDBEN at 0x0100 while in CPU → cpu_dout_valid pulses for 1 cycle with q = 0xC3. The same read while in RUN → no pulse.
- RESET_n low for 1 cycle during LOAD → ram_we = 0 and owner = 3 on the next cycle; the RST sequence restarts.
